// File: rtl/replay_pkg.sv
// rtl/replay_pkg.sv - shared types for the replay sequencing controller
package replay_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        KILL = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } replay_ctrl_state_t;

endpackage

// File: rtl/sat_cnt.sv
// rtl/sat_cnt.sv - saturating up-counter with synchronous clear
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !(&cnt_q))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/replay_ctrl.sv
// rtl/replay_ctrl.sv - stage-8 replay trigger, issue hold until fill/timeout,
// consecutive-replay halt and saturating replay statistic
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int N          = 10,
    parameter int TIMEOUT    = 64,
    parameter int MAX_REPLAY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s8_vld,
    input  logic             s8_miss,
    input  logic             fill_vld,
    input  logic [N-1:0]     ext_stall_req,
    output logic             replay_s8_w,
    output logic [N-1:0]     stall_req,
    output logic             busy,
    output logic             err_r,
    output logic [CNT_W-1:0] replay_cnt_r
);

    localparam int CW = $clog2(MAX_REPLAY + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    replay_ctrl_state_t state_q, state_d;
    logic [WW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]      consec_q;
    logic               err_q;
    logic               commit;

    assign replay_s8_w = (state_q == RUN) & s8_vld & s8_miss & ~rst;
    assign commit      = (state_q == RUN) & s8_vld & ~s8_miss;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (replay_s8_w)
                    state_d = (consec_q + CW'(1) == CW'(MAX_REPLAY)) ? HALT : KILL;
            end
            KILL: begin
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WW'(1);
                if (fill_vld || wait_cnt_q == WW'(TIMEOUT - 1))
                    state_d = RUN;
            end
            HALT: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (state_d == HALT)
                err_q <= 1'b1;
        end
    end

    // consecutive count saturates above MAX_REPLAY, so it can never wrap
    sat_cnt #(.W(CW)) u_consec (
        .clk   (clk),
        .rst   (rst),
        .clr_i (commit),
        .inc_i (replay_s8_w),
        .cnt_o (consec_q)
    );

    sat_cnt #(.W(CNT_W)) u_replay_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (replay_s8_w),
        .cnt_o (replay_cnt_r)
    );

    assign busy      = (state_q != RUN);
    assign stall_req = ext_stall_req | {{(N-1){1'b0}}, busy};
    assign err_r     = err_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// tb/tb_replay_ctrl.sv - directed self-checking bench for replay_ctrl
module tb_replay_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s8_vld, s8_miss, fill_vld;
    logic [9:0]  ext_stall_req;
    logic        replay_s8_w;
    logic [9:0]  stall_req;
    logic        busy, err_r;
    logic [15:0] replay_cnt_r;

    logic        sat_rst, sat_clr, sat_inc;
    logic [1:0]  sat_val;

    int tests  = 0;
    int failed = 0;
    int n;

    always #5 clk = ~clk;

    replay_ctrl #(.N(10), .TIMEOUT(64), .MAX_REPLAY(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .s8_vld        (s8_vld),
        .s8_miss       (s8_miss),
        .fill_vld      (fill_vld),
        .ext_stall_req (ext_stall_req),
        .replay_s8_w   (replay_s8_w),
        .stall_req     (stall_req),
        .busy          (busy),
        .err_r         (err_r),
        .replay_cnt_r  (replay_cnt_r)
    );

    sat_cnt #(.W(2)) u_sat (
        .clk   (clk),
        .rst   (sat_rst),
        .clr_i (sat_clr),
        .inc_i (sat_inc),
        .cnt_o (sat_val)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_op();
        s8_vld = 1'b1; s8_miss = 1'b0;
        step();
        s8_vld = 1'b0;
    endtask

    // miss, KILL, one WAIT cycle with fill, back to RUN
    task automatic replay_fill();
        s8_vld = 1'b1; s8_miss = 1'b1;
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        step();
        fill_vld = 1'b1;
        step();
        fill_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; s8_vld = 1'b1; s8_miss = 1'b1; fill_vld = 1'b0;
        ext_stall_req = 10'h000;
        sat_rst = 1'b1; sat_clr = 1'b0; sat_inc = 1'b0;
        #1;
        check("rst_no_replay", {31'd0, replay_s8_w}, 32'd0);
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err_r}, 32'd0);
        check("rst_cnt", {16'd0, replay_cnt_r}, 32'd0);
        check("rst_stall", {22'd0, stall_req}, 32'h0);
        rst = 1'b0; s8_vld = 1'b0; s8_miss = 1'b0; sat_rst = 1'b0;
        step();

        // miss then fill in the second WAIT cycle
        s8_vld = 1'b1; s8_miss = 1'b1;
        #1;
        check("t1_replay", {31'd0, replay_s8_w}, 32'd1);
        check("t1_busy_pre", {31'd0, busy}, 32'd0);
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        check("t1_kill_busy", {31'd0, busy}, 32'd1);
        check("t1_kill_stall", {31'd0, stall_req[0]}, 32'd1);
        step();
        s8_vld = 1'b1; s8_miss = 1'b1;
        #1;
        check("t1_wait_noreplay", {31'd0, replay_s8_w}, 32'd0);
        step();
        s8_vld = 1'b0; s8_miss = 1'b0; fill_vld = 1'b1;
        check("t1_wait2_busy", {31'd0, busy}, 32'd1);
        step();
        fill_vld = 1'b0;
        check("t1_run_busy", {31'd0, busy}, 32'd0);
        check("t1_run_stall", {31'd0, stall_req[0]}, 32'd0);
        check("t1_cnt", {16'd0, replay_cnt_r}, 32'd1);

        // timeout: KILL + 64 WAIT cycles
        s8_vld = 1'b1; s8_miss = 1'b1;
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        n = 0;
        while (stall_req[0] && n < 200) begin
            n++;
            step();
        end
        check("t2_stall_len", n, 32'd65);
        check("t2_busy", {31'd0, busy}, 32'd0);
        check("t2_err", {31'd0, err_r}, 32'd0);
        check("t2_cnt", {16'd0, replay_cnt_r}, 32'd2);

        // commit clears the consecutive count
        commit_op();
        for (int i = 0; i < 3; i++) replay_fill();
        commit_op();
        for (int i = 0; i < 3; i++) replay_fill();
        check("t4_no_halt", {31'd0, busy}, 32'd0);
        check("t4_err", {31'd0, err_r}, 32'd0);
        check("t4_cnt", {16'd0, replay_cnt_r}, 32'd8);
        commit_op();

        // fill dropped in RUN and KILL; stall merge
        fill_vld = 1'b1;
        step();
        fill_vld = 1'b0;
        check("t5_fill_run", {31'd0, busy}, 32'd0);
        s8_vld = 1'b1; s8_miss = 1'b1;
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        ext_stall_req = 10'h204; fill_vld = 1'b1;
        #1;
        check("t5_kill_merge", {22'd0, stall_req}, 32'h205);
        step();
        fill_vld = 1'b0;
        check("t5_fill_kill", {31'd0, busy}, 32'd1);
        check("t5_wait_merge", {22'd0, stall_req}, 32'h205);
        step();
        check("t5_wait_hold", {31'd0, busy}, 32'd1);
        fill_vld = 1'b1;
        step();
        fill_vld = 1'b0; ext_stall_req = 10'h000;
        check("t5_fill_exit", {31'd0, busy}, 32'd0);
        check("t5_cnt", {16'd0, replay_cnt_r}, 32'd9);
        commit_op();

        // fill coinciding with the last timeout cycle
        s8_vld = 1'b1; s8_miss = 1'b1;
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        step();
        repeat (63) step();
        check("t5_last_wait", {31'd0, busy}, 32'd1);
        fill_vld = 1'b1;
        step();
        fill_vld = 1'b0;
        check("t5_both_exit", {31'd0, busy}, 32'd0);
        step();
        check("t5_once", {31'd0, busy}, 32'd0);
        commit_op();

        // four consecutive replays halt
        for (int i = 0; i < 3; i++) replay_fill();
        s8_vld = 1'b1; s8_miss = 1'b1;
        #1;
        check("t3_4th_replay", {31'd0, replay_s8_w}, 32'd1);
        step();
        check("t3_err", {31'd0, err_r}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_cnt", {16'd0, replay_cnt_r}, 32'd14);
        check("t3_halt_noreplay", {31'd0, replay_s8_w}, 32'd0);
        fill_vld = 1'b1;
        step();
        step();
        fill_vld = 1'b0; s8_vld = 1'b0; s8_miss = 1'b0;
        check("t3_stuck_stall", {31'd0, stall_req[0]}, 32'd1);
        check("t3_stuck_cnt", {16'd0, replay_cnt_r}, 32'd14);

        // reset leaves HALT, then reset mid-WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_halt_exit", {31'd0, busy}, 32'd0);
        check("t6_err_clr", {31'd0, err_r}, 32'd0);
        s8_vld = 1'b1; s8_miss = 1'b1;
        step();
        s8_vld = 1'b0; s8_miss = 1'b0;
        step();
        step();
        check("t6_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1; s8_vld = 1'b1; s8_miss = 1'b1; ext_stall_req = 10'h0F0;
        #1;
        check("t6_rst_noreplay", {31'd0, replay_s8_w}, 32'd0);
        step();
        rst = 1'b0; s8_vld = 1'b0; s8_miss = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_stall", {22'd0, stall_req}, 32'h0F0);
        check("t6_err", {31'd0, err_r}, 32'd0);
        check("t6_cnt", {16'd0, replay_cnt_r}, 32'd0);

        // saturating counter holds at its maximum
        sat_inc = 1'b1;
        repeat (5) step();
        sat_inc = 1'b0;
        check("sat_hold", {30'd0, sat_val}, 32'd3);
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("sat_clr", {30'd0, sat_val}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
